// File: rtl/vref_step_sequencer_if.sv
// Switch/strobe inputs and LUT-index outputs of the vref step sequencer.
// master drives the switches and strobes; slave is the sequencer.
interface vref_step_sequencer_if;
  logic [3:0] sw_in;
  logic       sample_tick;
  logic       hold;
  logic [3:0] sel_out;
  logic       vref_valid;
  logic       busy;
  logic [3:0] target_out;

  modport master (
    output sw_in, sample_tick, hold,
    input  sel_out, vref_valid, busy, target_out
  );

  modport slave (
    input  sw_in, sample_tick, hold,
    output sel_out, vref_valid, busy, target_out
  );
endinterface

// File: rtl/vref_step_sequencer.sv
// Debounces the setpoint switches and ramps the reference LUT index
// one step per dwell period, with an immediate drop to index 0.
module vref_step_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DWELL_TICKS     = 100
) (
  input logic                  clk,
  input logic                  rst_n,
  vref_step_sequencer_if.slave io
);
  localparam int unsigned DBW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DWW =
    (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWW-1:0] DW_MAX = DWW'(DWELL_TICKS - 1);

  typedef enum logic {IDLE, RAMP} state_e;

  logic [3:0]     meta_q, sync_q;
  logic [3:0]     cand_q, cand_d;
  logic [3:0]     tgt_q, tgt_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;

  state_e         state_q;
  logic [3:0]     sel_q, sel_d, step_d;
  logic           valid_q, busy_q, done_q;
  logic [DWW-1:0] dw_cnt_q;
  logic           ready, in_ramp, moving;
  logic           zero_abort, go_idle, do_step, dw_inc;

  always_comb begin
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    tgt_d    = tgt_q;
    if (sync_q != cand_q) begin
      cand_d   = sync_q;
      db_cnt_d = '0;
      // a one-cycle debounce accepts on the first sample
      if (DEBOUNCE_CYCLES == 1) tgt_d = sync_q;
    end else begin
      if (db_cnt_q != DB_MAX) db_cnt_d = db_cnt_q + 1'b1;
      if (db_cnt_d == DB_MAX) tgt_d = cand_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      db_cnt_q <= '0;
      tgt_q    <= '0;
    end else begin
      meta_q   <= io.sw_in;
      sync_q   <= meta_q;
      cand_q   <= cand_d;
      db_cnt_q <= db_cnt_d;
      tgt_q    <= tgt_d;
    end
  end

  always_comb begin
    step_d = (tgt_q > sel_q) ? sel_q + 4'd1 : sel_q - 4'd1;
    ready   = done_q || (dw_cnt_q == DW_MAX);
    in_ramp = (state_q == RAMP);
    moving  = in_ramp && (tgt_q != sel_q);
    // dropping to the safe index ignores dwell and hold
    zero_abort = moving && (tgt_q == 4'd0) && io.sample_tick;
    go_idle = (in_ramp && (tgt_q == sel_q)) || zero_abort;
    do_step = moving && !zero_abort && io.sample_tick
              && !io.hold && ready;
    dw_inc  = moving && !zero_abort && io.sample_tick
              && !io.hold && !ready;
    sel_d = zero_abort ? 4'd0 : (do_step ? step_d : sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dw_cnt_q <= '0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= (sel_d != sel_q);
      busy_q  <= (sel_d != tgt_d);
      unique case (state_q)
        IDLE: begin
          if (tgt_q != sel_q) begin
            state_q  <= RAMP;
            done_q   <= 1'b1;
            dw_cnt_q <= '0;
          end
        end
        RAMP: begin
          unique case (1'b1)
            go_idle: state_q <= IDLE;
            do_step: begin
              dw_cnt_q <= '0;
              done_q   <= 1'b0;
              if (step_d == tgt_q) state_q <= IDLE;
            end
            dw_inc:  dw_cnt_q <= dw_cnt_q + 1'b1;
            default: ;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.sel_out    = sel_q;
  assign io.vref_valid = valid_q;
  assign io.busy       = busy_q;
  assign io.target_out = tgt_q;
endmodule

// File: tb/tb_vref_step_sequencer.sv
// Directed bench for vref_step_sequencer: window-based debounce model,
// tick-count ramp model, per-cycle compare plus literal pins.
module tb_vref_step_sequencer;
  localparam int DB = 4;
  localparam int DW = 3;
  localparam int HN = DB + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   tcnt = 0;

  vref_step_sequencer_if io ();

  vref_step_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .DWELL_TICKS(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  int         m_sel, m_tgt, m_prev;
  int         m_active, m_first, m_ticks;
  bit         m_valid, stable;
  logic [3:0] hist [HN];
  logic [3:0] pulses [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_tgt = 0; m_prev = 0; m_valid = 0;
    m_active = 0; m_first = 0; m_ticks = 0;
    for (int i = 0; i < HN; i++) hist[i] = 4'd0;
  endtask

  // Called at each active edge with the inputs the DUT sampled.
  task automatic model_step();
    m_prev = m_sel;
    if (m_active == 0) begin
      if (m_tgt != m_sel) begin
        m_active = 1; m_first = 1; m_ticks = 0;
      end
    end else if (m_tgt == m_sel) begin
      m_active = 0;
    end else if (m_tgt == 0 && io.sample_tick) begin
      m_sel = 0; m_active = 0;
    end else if (io.sample_tick && !io.hold) begin
      m_ticks++;
      if (m_first == 1 || m_ticks >= DW) begin
        m_sel = (m_tgt > m_sel) ? m_sel + 1 : m_sel - 1;
        m_ticks = 0; m_first = 0;
        if (m_sel == m_tgt) m_active = 0;
      end
    end
    for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = io.sw_in;
    // accept once DB consecutive synchronised samples agree
    stable = 1;
    for (int i = 3; i < HN; i++)
      if (hist[i] != hist[2]) stable = 0;
    if (stable) m_tgt = int'(hist[2]);
    m_valid = (m_sel != m_prev);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    tcnt++;
    io.sample_tick = (tcnt % 4 == 0);
  endtask

  task automatic rec();
    if (io.vref_valid) pulses.push_back(io.sel_out);
  endtask

  task automatic run_until(input logic [3:0] v, input string nm);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(); rec();
      if (io.sel_out == v && io.target_out == v && !io.busy) begin
        ok = 1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic wait_step(input logic [3:0] v, input string nm);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(); rec();
      if (io.vref_valid && io.sel_out == v) begin
        ok = 1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cmp_sel", int'(io.sel_out), m_sel);
        chk("cmp_valid", int'(io.vref_valid), int'(m_valid));
        chk("cmp_busy", int'(io.busy), int'(m_sel != m_tgt));
        chk("cmp_target", int'(io.target_out), m_tgt);
      end
    end
  end

  initial begin
    int g_bad, n, up_bad;
    bit ok;
    rst_n = 1'b0;
    io.sw_in = 4'd5;
    io.sample_tick = 1'b0;
    io.hold = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_sel", int'(io.sel_out), 0);
    chk("rst_target", int'(io.target_out), 0);
    chk("rst_valid", int'(io.vref_valid), 0);
    chk("rst_busy", int'(io.busy), 0);

    repeat (5) cyc();
    chk("db_early", int'(io.target_out), 0);
    cyc();
    chk("db_latency", int'(io.target_out), 5);
    pulses.delete();
    run_until(4'd5, "ramp5_done");
    chk("ramp5_pulses", pulses.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("ramp5_seq", int'(pulses[i]), i + 1);
    chk("ramp5_busy", int'(io.busy), 0);

    g_bad = 0;
    for (int k = 0; k < 7; k++) begin
      io.sw_in = (k % 2 == 0) ? 4'd7 : 4'd5;
      repeat (3) begin
        cyc();
        if (io.target_out != 4'd5) g_bad++;
      end
    end
    repeat (2) cyc();
    if (io.target_out != 4'd5) g_bad++;
    chk("glitch_hold", g_bad, 0);
    cyc();
    chk("glitch_accept", int'(io.target_out), 7);
    pulses.delete();
    run_until(4'd7, "ramp7_done");
    chk("ramp7_pulses", pulses.size(), 2);

    io.sw_in = 4'd12;
    run_until(4'd12, "ramp12_done");
    io.hold = 1'b1;
    io.sw_in = 4'd0;
    pulses.delete();
    run_until(4'd0, "abort_done");
    repeat (8) begin cyc(); rec(); end
    chk("abort_pulses", pulses.size(), 1);
    chk("abort_val", int'(pulses[0]), 0);
    chk("abort_sel", int'(io.sel_out), 0);
    io.hold = 1'b0;

    io.sw_in = 4'd8;
    pulses.delete();
    wait_step(4'd3, "redir_reach3");
    io.sw_in = 4'd1;
    run_until(4'd1, "redir_done");
    chk("redir_pulses", pulses.size(), 5);
    chk("redir_step1", int'(pulses[3]), 2);
    chk("redir_step2", int'(pulses[4]), 1);
    up_bad = 0;
    for (int i = 3; i < pulses.size(); i++)
      if (pulses[i] > pulses[i-1]) up_bad++;
    chk("redir_no_up", up_bad, 0);

    io.sw_in = 4'd9;
    wait_step(4'd4, "hold_reach4");
    io.hold = 1'b1;
    pulses.delete();
    repeat (40) begin cyc(); rec(); end
    chk("hold_pulses", pulses.size(), 0);
    chk("hold_sel", int'(io.sel_out), 4);
    io.hold = 1'b0;
    n = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (io.sample_tick) n++;
      cyc();
      if (io.sel_out == 4'd5) begin
        ok = 1;
        break;
      end
    end
    chk("hold_resume", int'(ok), 1);
    chk("hold_ticks", n, 3);

    wait_step(4'd6, "rst_reach6");
    #2 rst_n = 1'b0;
    io.sw_in = 4'd6;
    model_reset();
    #1;
    chk("async_sel", int'(io.sel_out), 0);
    chk("async_valid", int'(io.vref_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses.delete();
    run_until(4'd6, "restart_done");
    chk("restart_pulses", pulses.size(), 6);
    chk("restart_first", int'(pulses[0]), 1);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vref_step_sequencer.md
# vref_step_sequencer

Sequences the current-control setpoint index fed to the 16-entry reference-voltage lookup (index 0 = 0 A, indices 1..15 = increasing IEEE-754 setpoints). It debounces the front-panel switches and ramps the index one step at a time, synchronised to the control-loop sample strobe, so the current loop never sees a multi-step jump. Index 0 is the safe state and is always reached immediately. Sits between the board switches and the reference LUT, upstream of the current controller.

## Interface

- DEBOUNCE_CYCLES, 50000, consecutive clk cycles the synchronised switch value must be stable before it is accepted (>=1)
- DWELL_TICKS, 100, sample_tick pulses between successive ramp steps (>=1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw_in  in  4  raw asynchronous switch inputs
- sample_tick  in  1  one-cycle strobe from the control loop, one per sample period
- hold  in  1  freeze ramp (level); does not block the zero abort
- sel_out  out  4  registered index to reference LUT
- vref_valid  out  1  one-cycle pulse in the cycle after sel_out changes
- busy  out  1  high while sel_out != target
- target_out  out  4  debounced target index

## Operation

- Synchroniser: sw_in passes through 2 flops (sw_sync).
- Debouncer: candidate register plus stable counter. If sw_sync != candidate: candidate <= sw_sync, counter <= 0. Otherwise the counter increments, saturating. When the counter reaches DEBOUNCE_CYCLES-1 with a match, target <= candidate. The counter width is derived from DEBOUNCE_CYCLES.
- FSM states:
  - IDLE: sel_out == target. If target != sel_out, go to RAMP with dwell_done = 1, so the first step occurs on the next sample_tick.
  - RAMP: on sample_tick with dwell_done and !hold, sel_out steps by +1 or -1 toward target, and the dwell counter clears. The dwell counter counts sample_ticks only while !hold. dwell_done is set when DWELL_TICKS ticks have counted since the last step. If sel_out equals target after a step, go to IDLE.
- Direction is re-evaluated at every step from the current target.
  - If the target changes mid-ramp, the ramp redirects without returning to IDLE.
  - If the target becomes equal to sel_out, the FSM goes to IDLE on the next cycle with no step.
- Zero abort: if target == 0 and sel_out != 0, sel_out <= 0 on the next sample_tick. This ignores dwell and hold, then the FSM goes to IDLE.
- vref_valid pulses in the cycle after any sel_out change and never otherwise.
- busy = (sel_out != target), registered as part of the FSM.
- Index 15 is treated like any other index; the 14->15 transition is a single step.

## Timing

- Reset (async assert, sync to clk on release): sel_out = 0, target_out = 0, candidate = 0, vref_valid = 0, busy = 0, FSM = IDLE, counters = 0.
- Debounce latency from a sw_in change to a target_out change is 2 + DEBOUNCE_CYCLES clk cycles if there is no further sw_in activity. Any glitch restarts the count.
- Target to first step: the first sample_tick that is at least 1 cycle after the target update. A sample_tick in the same cycle as the target update is not used.
- Step spacing is exactly DWELL_TICKS sample_ticks, with hold-low ticks only.
- Maximum step rate: 1 step per sample_tick, when DWELL_TICKS = 1.
- Simultaneous events:
  - Zero abort has priority over hold and dwell.
  - A target change on the same edge as a step: the step uses the old target; the new one is used from the next edge.
- Reset mid-ramp: sel_out returns to 0 immediately (async) with no vref_valid pulse.

## Test plan

Use DEBOUNCE_CYCLES=4 and DWELL_TICKS=3.

- Reset then sw_in=5 held -> target_out=5 six cycles later. sel_out goes 1,2,3,4,5, with the first step on the next sample_tick and then every 3rd tick. There are five vref_valid pulses, then busy=0.
- sw_in=5->7 glitching every 3 cycles for 20 cycles, then stable at 7 -> target_out stays 5 during the glitching and becomes 7 exactly 6 cycles after the last change.
- Ramp at sel_out=3 toward 8, target changed to 1 -> the next step gives sel_out=2 and then 1. There are no upward steps after the redirect edge.
- hold=1 at sel_out=4 (target 9) for 10 ticks -> sel_out stays 4 and the dwell counter is frozen. After hold drops, the next step occurs after the remaining dwell ticks.
- sel_out=12, sw_in->0 with hold=1 -> after debounce, sel_out=0 on the next sample_tick, with one vref_valid pulse and FSM=IDLE.
- Assert rst_n=0 mid-ramp at sel_out=6 -> sel_out=0 asynchronously and vref_valid=0. After release with sw_in=6, the ramp restarts from 0.
